// File: rtl/lib_pkt_arb_mux.sv
// Packet-aware N:1 merge: per-source 2-deep skid FIFOs, round-robin packet grant
// held until EOP, single registered output stage tagged with the source index.
module lib_pkt_arb_mux #(
  parameter int NUM_INPUTS  = 4,
  parameter int LNUM_INPUTS = $clog2(NUM_INPUTS),
  parameter int DATA_W      = 512
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_INPUTS-1:0]        in_valid,
  output logic [NUM_INPUTS-1:0]        in_ready,
  input  logic [NUM_INPUTS*DATA_W-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]        in_sop,
  input  logic [NUM_INPUTS-1:0]        in_eop,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic [LNUM_INPUTS-1:0]       out_src,
  output logic                         err_orphan
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  state_e                  state_q, state_d;
  logic [LNUM_INPUTS-1:0]  lock_src_q, lock_src_d;
  logic [LNUM_INPUTS-1:0]  last_grant_q, last_grant_d;

  logic [DATA_W-1:0]       fifo_data_q [NUM_INPUTS][2];
  logic [1:0]              fifo_sop_q  [NUM_INPUTS];
  logic [1:0]              fifo_eop_q  [NUM_INPUTS];
  logic [1:0]              cnt_q       [NUM_INPUTS];
  logic [1:0]              cnt_d       [NUM_INPUTS];
  logic [NUM_INPUTS-1:0]   wr_ptr_q, rd_ptr_q;
  logic [NUM_INPUTS-1:0]   in_ready_q, in_ready_d;
  logic [NUM_INPUTS-1:0]   push, pop, nonempty;

  logic                    out_valid_q, out_valid_d;
  logic [DATA_W-1:0]       out_data_q, out_data_d;
  logic                    out_sop_q, out_sop_d;
  logic                    out_eop_q, out_eop_d;
  logic [LNUM_INPUTS-1:0]  out_src_q, out_src_d;
  logic                    err_orphan_q, err_orphan_d;

  logic                    grant_vld;
  logic [LNUM_INPUTS-1:0]  grant_src, cand;
  logic                    head_sel, head_sop, head_eop;
  logic [DATA_W-1:0]       head_data;
  logic                    load_en, load_grant;

  assign load_en    = !out_valid_q || out_ready;
  assign load_grant = load_en && grant_vld;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_src
    assign push[g]       = in_valid[g] & in_ready_q[g];
    assign pop[g]        = load_grant && (grant_src == LNUM_INPUTS'(g));
    assign nonempty[g]   = (cnt_q[g] != 2'd0);
    assign cnt_d[g]      = cnt_q[g] + {1'b0, push[g]} - {1'b0, pop[g]};
    assign in_ready_d[g] = (cnt_d[g] < 2'd2);
  end

  // Round-robin search starts just above last_grant, so last_grant itself is tried last.
  always_comb begin
    grant_vld = 1'b0;
    grant_src = last_grant_q;
    cand      = '0;
    if (state_q == ST_LOCKED) begin
      grant_vld = nonempty[lock_src_q];
      grant_src = lock_src_q;
    end else begin
      for (int k = 1; k <= NUM_INPUTS; k++) begin
        cand = LNUM_INPUTS'((int'(last_grant_q) + k) % NUM_INPUTS);
        if (!grant_vld && nonempty[cand]) begin
          grant_vld = 1'b1;
          grant_src = cand;
        end
      end
    end
  end

  assign head_sel  = rd_ptr_q[grant_src];
  assign head_data = fifo_data_q[grant_src][head_sel];
  assign head_sop  = fifo_sop_q[grant_src][head_sel];
  assign head_eop  = fifo_eop_q[grant_src][head_sel];

  always_comb begin
    state_d      = state_q;
    lock_src_d   = lock_src_q;
    last_grant_d = last_grant_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sop_d    = out_sop_q;
    out_eop_d    = out_eop_q;
    out_src_d    = out_src_q;
    err_orphan_d = 1'b0;
    if (load_grant) begin
      out_valid_d = 1'b1;
      out_data_d  = head_data;
      out_sop_d   = head_sop;
      out_eop_d   = head_eop;
      out_src_d   = grant_src;
      if (state_q == ST_IDLE) begin
        if (head_sop && !head_eop) begin
          state_d    = ST_LOCKED;
          lock_src_d = grant_src;
        end else begin
          // Single-beat packet or orphan continuation: both pass as one beat.
          last_grant_d = grant_src;
          err_orphan_d = !head_sop;
        end
      end else if (head_eop) begin
        state_d      = ST_IDLE;
        last_grant_d = lock_src_q;
      end
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      lock_src_q   <= '0;
      last_grant_q <= '0;
      in_ready_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) cnt_q[i] <= 2'd0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_src_q    <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_src_q   <= lock_src_d;
      last_grant_q <= last_grant_d;
      in_ready_q   <= in_ready_d;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (push[i]) wr_ptr_q[i] <= ~wr_ptr_q[i];
        if (pop[i])  rd_ptr_q[i] <= ~rd_ptr_q[i];
      end
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      out_src_q    <= out_src_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  // Skid storage is only read while its occupancy count says it is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (push[i]) begin
        fifo_data_q[i][wr_ptr_q[i]] <= in_data[i*DATA_W +: DATA_W];
        fifo_sop_q[i][wr_ptr_q[i]]  <= in_sop[i];
        fifo_eop_q[i][wr_ptr_q[i]]  <= in_eop[i];
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sop    = out_sop_q;
  assign out_eop    = out_eop_q;
  assign out_src    = out_src_q;
  assign err_orphan = err_orphan_q;

endmodule
